// File: rtl/lane_shift_pkg.sv
// rtl/lane_shift_pkg.sv - lane-shift mode enum and keep-mask helper
package lane_shift_pkg;

  localparam int unsigned MAX_LANES = 64;

  typedef enum logic [1:0] {
    SHIFT_DN = 2'd0,
    SHIFT_UP = 2'd1,
    ROT_DN   = 2'd2,
    RSVD     = 2'd3
  } lane_mode_e;

  // Bit i is set when output lane i is sourced from an input lane.
  function automatic logic [MAX_LANES-1:0] keep_mask(input lane_mode_e mode,
                                                     input int unsigned k,
                                                     input int unsigned n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < n) begin
        case (mode)
          SHIFT_DN: m[i] = (i + k < n);
          SHIFT_UP: m[i] = (i >= k);
          ROT_DN:   m[i] = 1'b1;
          default:  m[i] = 1'b0;
        endcase
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lane_shift_core.sv
// rtl/lane_shift_core.sv - combinational lane shift/rotate network with keep mask
module lane_shift_core
  import lane_shift_pkg::*;
#(
  parameter  int unsigned NUM_LANES = 16,
  parameter  int unsigned LANE_W    = 16,
  localparam int unsigned SH_W      = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0][LANE_W-1:0] in_lanes,
  input  logic [SH_W-1:0]                  in_shift,
  input  lane_mode_e                       in_mode,
  output logic [NUM_LANES-1:0][LANE_W-1:0] out_lanes,
  output logic [NUM_LANES-1:0]             out_keep,
  output logic                             out_err
);

  logic [MAX_LANES-1:0] w_mask;
  logic [31:0]          w_k;

  assign w_k      = 32'(in_shift);
  assign w_mask   = keep_mask(in_mode, w_k, NUM_LANES);
  assign out_keep = w_mask[NUM_LANES-1:0];
  assign out_err  = (in_mode == RSVD);

  // The keep mask gates every lane, so out-of-range source indices never reach the output.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [31:0] w_src;
    always_comb begin
      w_src = 32'(g) + w_k;
      case (in_mode)
        SHIFT_UP: w_src = 32'(g) - w_k;
        ROT_DN:   w_src = (32'(g) + w_k) % NUM_LANES;
        default:  w_src = 32'(g) + w_k;
      endcase
    end
    assign out_lanes[g] = w_mask[g] ? in_lanes[w_src[SH_W-1:0]] : '0;
  end

endmodule

// File: rtl/lane_shift_pipe.sv
// rtl/lane_shift_pipe.sv - two-stage valid/ready pipeline around lane_shift_core
module lane_shift_pipe
  import lane_shift_pkg::*;
#(
  parameter  int unsigned NUM_LANES = 16,
  parameter  int unsigned LANE_W    = 16,
  localparam int unsigned SH_W      = $clog2(NUM_LANES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] in_data,
  input  logic [SH_W-1:0]                  in_shift,
  input  logic [1:0]                       in_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES-1:0][LANE_W-1:0] out_data,
  output logic [NUM_LANES-1:0]             out_keep,
  output logic                             out_err
);

  logic                             r_s1_valid;
  logic [NUM_LANES-1:0][LANE_W-1:0] r_s1_data;
  logic [SH_W-1:0]                  r_s1_shift;
  lane_mode_e                       r_s1_mode;

  logic                             r_out_valid;
  logic [NUM_LANES-1:0][LANE_W-1:0] r_out_data;
  logic [NUM_LANES-1:0]             r_out_keep;
  logic                             r_out_err;

  logic                             w_en1;
  logic                             w_en2;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_lanes;
  logic [NUM_LANES-1:0]             w_keep;
  logic                             w_err;

  // out_ready feeds in_ready combinationally; integrators must not close a loop through it.
  assign w_en2    = !r_out_valid || out_ready;
  assign w_en1    = !r_s1_valid || w_en2;
  assign in_ready = w_en1;

  lane_shift_core #(
    .NUM_LANES(NUM_LANES),
    .LANE_W   (LANE_W)
  ) u_core (
    .in_lanes (r_s1_data),
    .in_shift (r_s1_shift),
    .in_mode  (r_s1_mode),
    .out_lanes(w_lanes),
    .out_keep (w_keep),
    .out_err  (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_shift  <= '0;
      r_s1_mode   <= SHIFT_DN;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_en1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data  <= in_data;
          r_s1_shift <= in_shift;
          r_s1_mode  <= lane_mode_e'(in_mode);
        end
      end
      if (w_en2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_lanes;
          r_out_keep <= w_keep;
          r_out_err  <= w_err;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_err   = r_out_err;

endmodule

// File: doc/lane_shift_pipe.md
# lane_shift_pipe

Pipelined, parametrised lane shifter for multi-lane datapaths. Accepts one vector of `NUM_LANES` lanes of `LANE_W` bits per handshake and emits it realigned by a per-transfer shift amount in one of three modes: shift-down zero-fill, shift-up zero-fill, or rotate-down. It sits between a lane-parallel producer and consumer on a valid/ready stream, supplies a per-lane keep mask, and sustains one transfer per cycle under backpressure.

## Interface
- `NUM_LANES`, 16: lane count, 2..64.
- `LANE_W`, 16: bits per lane, at least 1.
- `SH_W`, `$clog2(NUM_LANES)`: shift-amount width. Derived; do not override.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- `in_valid` input 1: input vector valid.
- `in_ready` output 1: block accepts the input vector this cycle.
- `in_data` input `NUM_LANES`×`LANE_W`: input lanes, `in_data[i]` = lane i.
- `in_shift` input `SH_W`: shift amount.
- `in_mode` input 2: 0 = SHIFT_DN, 1 = SHIFT_UP, 2 = ROT_DN, 3 = reserved.
- `out_valid` output 1: output vector valid.
- `out_ready` input 1: consumer accepts the output vector.
- `out_data` output `NUM_LANES`×`LANE_W`: realigned lanes.
- `out_keep` output `NUM_LANES`: 1 = the lane carries input data; 0 = the lane is zero-filled.
- `out_err` output 1: the transfer used the reserved mode.

## Operation
- Transfer rules: an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`. `in_data`, `in_shift` and `in_mode` are sampled together with the transfer.
- Let k = `in_shift` and N = `NUM_LANES`. For each output lane i:
  - SHIFT_DN: `out[i] = in[i+k]` when i+k < N, otherwise 0. This is the legacy behaviour.
  - SHIFT_UP: `out[i] = in[i-k]` when i ≥ k, otherwise 0.
  - ROT_DN: `out[i] = in[(i+k) mod N]`; all `out_keep` bits are 1.
  - Reserved: all `out_data` lanes are 0, `out_keep` = 0, `out_err` = 1. The transfer is still handshaked and is not dropped.
- k ≥ N: this is only possible when N is not a power of two.
  - Shift modes produce all zeros and `out_keep` = 0.
  - ROT_DN uses k mod N.
- k = 0: output equals input in every mode, and `out_keep` is all ones (except in the reserved mode).
- `out_keep[i]` is 1 exactly where the lane was sourced from an input lane.
- Ordering: vectors exit in the order they were accepted. No vector is dropped or duplicated.

## Timing
- Two register stages:
  - S1 captures the raw vector, k and mode.
  - S2 holds the shifted result.
  - The shift network sits between S1 and S2.
- Latency: 2 cycles from input transfer to `out_valid`, when S1 and S2 are empty or advancing.
- Stage enables:
  - en2 = `!out_valid || out_ready`.
  - en1 = `!s1_valid || en2`.
  - `in_ready` = en1.
- `out_ready` reaches `in_ready` combinationally. This path is accepted and documented for integrators.
- Throughput: 1 vector per cycle while `out_ready` = 1.
- Full: both stages valid and `out_ready` = 0 gives `in_ready` = 0. The held `out_data`, `out_keep` and `out_err` stay stable.
- Simultaneous input and output transfer in the same cycle when full: both stages advance with no bubble.
- AXI-style rules:
  - `out_valid` does not depend on `out_ready`.
  - Once `out_valid` is asserted, it and the payload hold until the output transfer.
- Reset values (async, immediate on `rst_n` = 0):
  - `s1_valid` = 0, `out_valid` = 0.
  - `out_data` = 0, `out_keep` = 0, `out_err` = 0.
  - `in_ready` = 1 after reset.
- Reset mid-operation flushes both stages. No vector in flight survives.

## Structure
- Shared package `lane_shift_pkg`:
  - `lane_mode_e` enum: SHIFT_DN, SHIFT_UP, ROT_DN, RSVD.
  - Helper function computing the keep mask from (mode, k, N).
- Sub-module `lane_shift_core`:
  - Purely combinational, parametrised by `NUM_LANES` and `LANE_W`.
  - Inputs: lanes, k, mode. Outputs: lanes, keep, err.
  - Reusable by other datapath blocks.
- Top level `lane_shift_pipe`: the S1/S2 registers and the handshake control.

## Test plan
1. Defaults, `in_data[i]` = 16'h1000+i, SHIFT_DN, k = 3, `out_ready` = 1 → two cycles later `out_data[0]` = 16'h1003, `out_data[12]` = 16'h100F, lanes 13–15 = 0, `out_keep` = 16'h1FFF.
2. Same data:
   - SHIFT_UP, k = 5 → lanes 0–4 = 0, `out_data[5]` = 16'h1000, `out_keep` = 16'hFFE0.
   - ROT_DN, k = 15 → `out_data[0]` = 16'h100F, `out_data[1]` = 16'h1000, `out_keep` = 16'hFFFF.
3. Backpressure: 6 back-to-back vectors with `out_ready` = 0 for cycles 2–7.
   - `in_ready` falls after 2 accepts; `out_data` stays stable.
   - After release, all 6 vectors exit in order, one per cycle.
4. `in_mode` = 3, k = 2 → `out_data` all 0, `out_keep` = 0, `out_err` = 1; the next valid-mode vector has `out_err` = 0.
5. `NUM_LANES` = 12, `LANE_W` = 8:
   - SHIFT_DN, k = 13 → all zero, `out_keep` = 0.
   - ROT_DN, k = 13 → `out_data[0]` = `in[1]`.
6. Assert `rst_n` = 0 with both stages full → `out_valid`, `out_keep` and `out_err` go to 0 immediately. After release, `in_ready` = 1 and no stale vector appears.
